// File: rtl/jmp_unit.sv
// Branch/jump unit: gathers a multi-byte target, evaluates a flag condition and
// issues abs/rel/call/ret PC updates backed by a hardware return-address stack.
module jmp_unit #(
  parameter int unsigned ADDR_W      = 16,
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned STACK_DEPTH = 8
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               start,
  input  logic [1:0]                         kind,
  input  logic [3:0]                         cond,
  input  logic [ADDR_W-1:0]                  pc_in,
  input  logic [DATA_W-1:0]                  data_in,
  input  logic                               data_valid,
  input  logic                               zflag,
  input  logic                               oflag,
  input  logic                               cflag,
  input  logic                               sflag,
  input  logic                               err_clr,
  output logic                               busy,
  output logic                               done,
  output logic                               pc_we,
  output logic [ADDR_W-1:0]                  pc_out,
  output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
  output logic                               stack_full,
  output logic                               stack_empty,
  output logic                               err_ovf,
  output logic                               err_unf
);

  localparam int unsigned NBYTES = ADDR_W / DATA_W;
  localparam int unsigned SP_W   = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IDX_W  = $clog2(STACK_DEPTH);
  localparam int unsigned CNT_W  = $clog2(NBYTES + 1);

  localparam logic [1:0] K_ABS  = 2'b00;
  localparam logic [1:0] K_REL  = 2'b01;
  localparam logic [1:0] K_CALL = 2'b10;
  localparam logic [1:0] K_RET  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_RESOLVE = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t              r_state;
  logic [1:0]          r_kind;
  logic [3:0]          r_cond;
  logic [ADDR_W-1:0]   r_pc_base;
  logic [ADDR_W-1:0]   r_tgt;
  logic [CNT_W-1:0]    r_cnt;
  logic [SP_W-1:0]     r_sp;
  logic [ADDR_W-1:0]   r_stack [STACK_DEPTH];
  logic                r_busy;
  logic                r_done;
  logic                r_pc_we;
  logic [ADDR_W-1:0]   r_pc_out;
  logic                r_err_ovf;
  logic                r_err_unf;

  logic                w_full;
  logic                w_empty;
  logic                w_cond_true;
  logic [IDX_W-1:0]    w_push_idx;
  logic [IDX_W-1:0]    w_top_idx;

  assign w_full     = (r_sp == SP_W'(STACK_DEPTH));
  assign w_empty    = (r_sp == '0);
  assign w_push_idx = IDX_W'(r_sp);
  assign w_top_idx  = IDX_W'(r_sp - SP_W'(1));

  // Condition codes evaluated against the live ALU flags during RESOLVE
  always_comb begin
    w_cond_true = 1'b0;
    case (r_cond)
      4'd0:    w_cond_true = 1'b1;
      4'd1:    w_cond_true = zflag;
      4'd2:    w_cond_true = !zflag;
      4'd3:    w_cond_true = cflag;
      4'd4:    w_cond_true = cflag | zflag;
      4'd5:    w_cond_true = !(cflag | zflag);
      4'd6:    w_cond_true = !cflag;
      4'd7:    w_cond_true = oflag ^ sflag;
      4'd8:    w_cond_true = (oflag ^ sflag) | zflag;
      4'd9:    w_cond_true = !(oflag ^ sflag) & !zflag;
      4'd10:   w_cond_true = !(oflag ^ sflag);
      default: w_cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_kind    <= '0;
      r_cond    <= '0;
      r_pc_base <= '0;
      r_tgt     <= '0;
      r_cnt     <= '0;
      r_sp      <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_pc_we   <= 1'b0;
      r_pc_out  <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) r_stack[i] <= '0;
    end else begin
      // err_clr wins over any error raised in the same cycle
      if (err_clr) begin
        r_err_ovf <= 1'b0;
        r_err_unf <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_busy    <= 1'b1;
            r_kind    <= kind;
            r_cond    <= cond;
            r_pc_base <= pc_in;
            r_tgt     <= '0;
            r_cnt     <= '0;
            r_state   <= (kind == K_RET) ? S_RESOLVE : S_COLLECT;
          end
        end
        S_COLLECT: begin
          if (data_valid) begin
            r_tgt <= ADDR_W'({r_tgt, data_in});
            if (r_cnt == CNT_W'(NBYTES - 1)) r_state <= S_RESOLVE;
            else                             r_cnt   <= r_cnt + CNT_W'(1);
          end
        end
        S_RESOLVE: begin
          r_done   <= 1'b1;
          r_pc_we  <= 1'b0;
          r_pc_out <= '0;
          r_state  <= S_DONE;
          if (w_cond_true) begin
            case (r_kind)
              K_ABS: begin
                r_pc_we  <= 1'b1;
                r_pc_out <= r_tgt;
              end
              K_REL: begin
                r_pc_we  <= 1'b1;
                r_pc_out <= r_pc_base + r_tgt;
              end
              K_CALL: begin
                if (w_full) begin
                  if (!err_clr) r_err_ovf <= 1'b1;
                end else begin
                  r_stack[w_push_idx] <= r_pc_base;
                  r_sp                <= r_sp + SP_W'(1);
                  r_pc_we             <= 1'b1;
                  r_pc_out            <= r_tgt;
                end
              end
              default: begin
                if (w_empty) begin
                  if (!err_clr) r_err_unf <= 1'b1;
                end else begin
                  r_sp     <= r_sp - SP_W'(1);
                  r_pc_we  <= 1'b1;
                  r_pc_out <= r_stack[w_top_idx];
                end
              end
            endcase
          end
        end
        S_DONE: begin
          r_done   <= 1'b0;
          r_pc_we  <= 1'b0;
          r_pc_out <= '0;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy        = r_busy;
  assign done        = r_done;
  assign pc_we       = r_pc_we;
  assign pc_out      = r_pc_out;
  assign sp          = r_sp;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign err_ovf     = r_err_ovf;
  assign err_unf     = r_err_unf;

endmodule

// File: tb/tb_jmp_unit.sv
// Directed bench for jmp_unit: hand-computed targets, latencies, stack and error behaviour.
module tb_jmp_unit;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [1:0]  kind;
  logic [3:0]  cond;
  logic [15:0] pc_in;
  logic [7:0]  data_in;
  logic        data_valid;
  logic        zflag, oflag, cflag, sflag;
  logic        err_clr;
  logic        busy, done, pc_we;
  logic [15:0] pc_out;
  logic [3:0]  sp;
  logic        stack_full, stack_empty, err_ovf, err_unf;

  int n_vec = 0;
  int n_err = 0;

  jmp_unit #(.ADDR_W(16), .DATA_W(8), .STACK_DEPTH(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .kind(kind), .cond(cond),
    .pc_in(pc_in), .data_in(data_in), .data_valid(data_valid),
    .zflag(zflag), .oflag(oflag), .cflag(cflag), .sflag(sflag),
    .err_clr(err_clr), .busy(busy), .done(done), .pc_we(pc_we),
    .pc_out(pc_out), .sp(sp), .stack_full(stack_full),
    .stack_empty(stack_empty), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation; lat counts cycles from the start cycle (T0) to the done cycle.
  task automatic run_op(input logic [1:0] k, input logic [3:0] c, input logic [15:0] pc,
                        input logic [15:0] tgt, input int gap, input logic busy_start,
                        output int lat, output logic we, output logic [15:0] pco);
    int t;
    logic [7:0] bytes [2];
    bytes[0] = tgt[15:8];
    bytes[1] = tgt[7:0];
    @(negedge clk);
    t = 0;
    start = 1'b1; kind = k; cond = c; pc_in = pc;
    @(negedge clk);
    t++;
    start = 1'b0;
    if (k != 2'b11) begin
      for (int i = 0; i < 2; i++) begin
        for (int g = 0; g < gap; g++) begin
          data_valid = 1'b0;
          start = busy_start; kind = 2'b11;
          @(negedge clk);
          t++;
        end
        start = 1'b0;
        data_valid = 1'b1; data_in = bytes[i];
        @(negedge clk);
        t++;
      end
      data_valid = 1'b0;
    end
    while (!done && t < 60) begin
      @(negedge clk);
      t++;
    end
    lat = t;
    we  = pc_we;
    pco = pc_out;
    if (!done) chk("done_timeout", 32'(done), 32'd1);
    @(negedge clk);
    chk("done_pulse", 32'(done), 32'd0);
    chk("busy_after", 32'(busy), 32'd0);
  endtask

  initial begin
    int          lat;
    logic        we;
    logic [15:0] pco;

    rst_n = 1'b0; start = 1'b0; kind = '0; cond = '0; pc_in = '0;
    data_in = '0; data_valid = 1'b0; err_clr = 1'b0;
    zflag = 1'b0; oflag = 1'b0; cflag = 1'b0; sflag = 1'b0;
    repeat (3) @(negedge clk);

    chk("rst_busy",  32'(busy), 32'd0);
    chk("rst_done",  32'(done), 32'd0);
    chk("rst_pcwe",  32'(pc_we), 32'd0);
    chk("rst_pcout", 32'(pc_out), 32'd0);
    chk("rst_sp",    32'(sp), 32'd0);
    chk("rst_empty", 32'(stack_empty), 32'd1);
    chk("rst_full",  32'(stack_full), 32'd0);
    chk("rst_errs",  32'({err_ovf, err_unf}), 32'd0);
    rst_n = 1'b1;

    // Absolute jump, always
    run_op(2'b00, 4'd0, 16'h0000, 16'h1234, 0, 1'b0, lat, we, pco);
    chk("abs_lat", 32'(lat), 32'd4);
    chk("abs_we",  32'(we), 32'd1);
    chk("abs_pc",  32'(pco), 32'h1234);

    // Relative jump with wrap, taken on z
    zflag = 1'b1;
    run_op(2'b01, 4'd1, 16'hFFF0, 16'h0020, 0, 1'b0, lat, we, pco);
    chk("rel_lat", 32'(lat), 32'd4);
    chk("rel_we",  32'(we), 32'd1);
    chk("rel_pc",  32'(pco), 32'h0010);
    zflag = 1'b0;
    run_op(2'b01, 4'd1, 16'hFFF0, 16'h0020, 0, 1'b0, lat, we, pco);
    chk("reln_lat", 32'(lat), 32'd4);
    chk("reln_we",  32'(we), 32'd0);
    chk("reln_pc",  32'(pco), 32'h0000);

    // Assorted condition codes
    oflag = 1'b1; sflag = 1'b1; zflag = 1'b0; cflag = 1'b0;
    run_op(2'b00, 4'd9, 16'h0000, 16'hBEEF, 0, 1'b0, lat, we, pco);
    chk("c9_we", 32'(we), 32'd1);
    chk("c9_pc", 32'(pco), 32'hBEEF);
    run_op(2'b00, 4'd7, 16'h0000, 16'hBEEF, 0, 1'b0, lat, we, pco);
    chk("c7_we", 32'(we), 32'd0);
    run_op(2'b00, 4'd5, 16'h0000, 16'h4321, 0, 1'b0, lat, we, pco);
    chk("c5_pc", 32'(pco), 32'h4321);
    cflag = 1'b1;
    run_op(2'b00, 4'd5, 16'h0000, 16'h4321, 0, 1'b0, lat, we, pco);
    chk("c5n_we", 32'(we), 32'd0);
    run_op(2'b00, 4'd13, 16'h0000, 16'h4321, 0, 1'b0, lat, we, pco);
    chk("c13_we", 32'(we), 32'd0);
    oflag = 1'b0; sflag = 1'b0; cflag = 1'b0;

    // Fill the return stack
    for (int i = 0; i < 8; i++) begin
      run_op(2'b10, 4'd0, 16'h0100 + 16'(i), 16'h2000 + 16'(i), 0, 1'b0, lat, we, pco);
      chk("call_pc", 32'(pco), 32'h2000 + 32'(i));
      chk("call_sp", 32'(sp), 32'(i + 1));
    end
    chk("full", 32'(stack_full), 32'd1);
    run_op(2'b10, 4'd0, 16'h0999, 16'h3000, 0, 1'b0, lat, we, pco);
    chk("ovf_we",  32'(we), 32'd0);
    chk("ovf_err", 32'(err_ovf), 32'd1);
    chk("ovf_sp",  32'(sp), 32'd8);

    // Drain it in LIFO order
    for (int i = 0; i < 8; i++) begin
      run_op(2'b11, 4'd0, 16'h0000, 16'h0000, 0, 1'b0, lat, we, pco);
      chk("ret_lat", 32'(lat), 32'd2);
      chk("ret_we",  32'(we), 32'd1);
      chk("ret_pc",  32'(pco), 32'h0107 - 32'(i));
    end
    chk("empty", 32'(stack_empty), 32'd1);

    // Underflow, clear, and clear racing a new error
    run_op(2'b11, 4'd0, 16'h0000, 16'h0000, 0, 1'b0, lat, we, pco);
    chk("unf_we",  32'(we), 32'd0);
    chk("unf_err", 32'(err_unf), 32'd1);
    chk("ovf_sticky", 32'(err_ovf), 32'd1);
    err_clr = 1'b1;
    @(negedge clk);
    chk("clr_errs", 32'({err_ovf, err_unf}), 32'd0);
    run_op(2'b11, 4'd0, 16'h0000, 16'h0000, 0, 1'b0, lat, we, pco);
    err_clr = 1'b0;
    @(negedge clk);
    chk("clr_race", 32'(err_unf), 32'd0);

    // Byte gaps with start pulses while busy
    run_op(2'b00, 4'd0, 16'h0000, 16'h1234, 3, 1'b1, lat, we, pco);
    chk("gap_lat", 32'(lat), 32'd10);
    chk("gap_pc",  32'(pco), 32'h1234);
    repeat (3) @(negedge clk);
    chk("gap_idle", 32'({busy, sp}), 32'd0);

    // Reset in the middle of collecting
    run_op(2'b10, 4'd0, 16'h0555, 16'h0AAA, 0, 1'b0, lat, we, pco);
    chk("pre_sp", 32'(sp), 32'd1);
    @(negedge clk);
    start = 1'b1; kind = 2'b00; cond = 4'd0;
    @(negedge clk);
    start = 1'b0; data_valid = 1'b1; data_in = 8'h77;
    @(negedge clk);
    data_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_sp",   32'(sp), 32'd0);
    chk("mid_out",  32'({done, pc_we}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_out", 32'({busy, done, pc_we}), 32'd0);
    run_op(2'b00, 4'd0, 16'h0000, 16'h00AB, 0, 1'b0, lat, we, pco);
    chk("post_lat", 32'(lat), 32'd4);
    chk("post_pc",  32'(pco), 32'h00AB);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
